// File: rtl/sprite_linebuf_pp_if.sv
// Renderer/scanout side of the ping-pong sprite line buffer.
// The master drives write/read/swap requests; the slave returns pixel data and status.
interface sprite_linebuf_pp_if #(
    parameter int COLOR_W = 4,
    parameter int PAL_W   = 8,
    parameter int ADDR_W  = 8
);
    logic                     WR_LOAD;
    logic [ADDR_W-1:0]        WR_X;
    logic                     WR_DIR;
    logic                     WR_PAL_LD;
    logic [PAL_W-1:0]         WR_PAL;
    logic                     WR_EN;
    logic [COLOR_W-1:0]       COLOR_INDEX;
    logic                     RD_START;
    logic                     RD_EN;
    logic                     SWAP;
    logic [PAL_W+COLOR_W-1:0] DATA_OUT;
    logic                     BUSY;
    logic                     BANK;

    modport master (
        output WR_LOAD, WR_X, WR_DIR, WR_PAL_LD, WR_PAL, WR_EN, COLOR_INDEX,
        output RD_START, RD_EN, SWAP,
        input  DATA_OUT, BUSY, BANK
    );

    modport slave (
        input  WR_LOAD, WR_X, WR_DIR, WR_PAL_LD, WR_PAL, WR_EN, COLOR_INDEX,
        input  RD_START, RD_EN, SWAP,
        output DATA_OUT, BUSY, BANK
    );
endinterface

// File: rtl/sprite_linebuf_pp.sv
// Two-bank sprite line buffer: renderer fills the back bank while scanout reads
// and clears the front bank; SWAP exchanges them at each line boundary.
module sprite_linebuf_pp #(
    parameter int COLOR_W = 4,
    parameter int PAL_W   = 8,
    parameter int DEPTH   = 192,
    parameter int ADDR_W  = 8
) (
    input  logic                CLK,
    input  logic                nRESET,
    sprite_linebuf_pp_if.slave  bus
);
    localparam int                DW       = PAL_W + COLOR_W;
    localparam logic [DW-1:0]     BD       = {DW{1'b1}};
    localparam logic [ADDR_W-1:0] K_LAST   = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_k;
    logic              r_busy;
    logic              r_bank;
    logic [ADDR_W-1:0] r_wcnt;
    logic              r_dir;
    logic [PAL_W-1:0]  r_pal;
    logic [ADDR_W:0]   r_rcnt;   // one extra bit so it can rest at DEPTH
    logic [DW-1:0]     r_dout;
    logic [DW-1:0]     r_mem [2][DEPTH];

    logic [ADDR_W-1:0] w_waddr;
    logic [ADDR_W-1:0] w_wnext;
    logic              w_dir;
    logic              w_wr;
    logic              w_rd;
    logic              w_rd_in;
    logic              w_clr;

    assign w_waddr = bus.WR_LOAD ? bus.WR_X : r_wcnt;
    assign w_dir   = bus.WR_LOAD ? bus.WR_DIR : r_dir;
    assign w_wnext = w_dir ? (w_waddr - ADDR_W'(1)) : (w_waddr + ADDR_W'(1));
    assign w_wr    = ~r_busy & bus.WR_EN & (|bus.COLOR_INDEX) & ({1'b0, w_waddr} < DEPTH_X);
    // RD_START takes the cycle: the counter restarts and no pixel is consumed.
    assign w_rd    = ~r_busy & bus.RD_EN & ~bus.RD_START;
    assign w_rd_in = r_rcnt < DEPTH_X;
    assign w_clr   = w_rd & w_rd_in;

    // Back bank takes pixels, front bank takes clear-behind; never the same bank.
    always_ff @(posedge CLK) begin
        if (r_busy) begin
            r_mem[0][r_k] <= BD;
            r_mem[1][r_k] <= BD;
        end else begin
            if (w_wr)  r_mem[~r_bank][w_waddr] <= {r_pal, bus.COLOR_INDEX};
            if (w_clr) r_mem[r_bank][r_rcnt[ADDR_W-1:0]] <= BD;
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_state <= S_INIT;
            r_k     <= '0;
            r_busy  <= 1'b1;
            r_bank  <= 1'b0;
            r_wcnt  <= '0;
            r_dir   <= 1'b0;
            r_pal   <= '0;
            r_rcnt  <= '0;
            r_dout  <= BD;
        end else begin
            case (r_state)
                S_INIT: begin
                    r_k <= r_k + ADDR_W'(1);
                    if (r_k == K_LAST) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (bus.WR_PAL_LD) r_pal <= bus.WR_PAL;
                    if (bus.WR_LOAD) begin
                        r_wcnt <= bus.WR_X;
                        r_dir  <= bus.WR_DIR;
                    end
                    if (bus.WR_EN) r_wcnt <= w_wnext;
                    if (w_rd) begin
                        r_dout <= w_rd_in ? r_mem[r_bank][r_rcnt[ADDR_W-1:0]] : BD;
                        if (w_rd_in) r_rcnt <= r_rcnt + (ADDR_W+1)'(1);
                    end
                    if (bus.RD_START || bus.SWAP) r_rcnt <= '0;
                    if (bus.SWAP) r_bank <= ~r_bank;
                end
                default: r_state <= S_INIT;
            endcase
        end
    end

    assign bus.DATA_OUT = r_dout;
    assign bus.BUSY     = r_busy;
    assign bus.BANK     = r_bank;
endmodule

// File: tb/tb_sprite_linebuf_pp.sv
// Directed bench for sprite_linebuf_pp: init sweep, strip write, flip/wrap,
// clear-behind, simultaneous events and mid-sweep reset.
module tb_sprite_linebuf_pp;
    localparam int COLOR_W = 4;
    localparam int PAL_W   = 8;
    localparam int DEPTH   = 192;
    localparam int ADDR_W  = 8;
    localparam logic [11:0] BD = 12'hFFF;

    logic clk;
    logic nrst;
    int   n_cmp;
    int   n_err;
    int   n;
    logic [11:0] exp_line [0:255];

    sprite_linebuf_pp_if #(.COLOR_W(COLOR_W), .PAL_W(PAL_W), .ADDR_W(ADDR_W)) bus ();

    sprite_linebuf_pp #(.COLOR_W(COLOR_W), .PAL_W(PAL_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .CLK    (clk),
        .nRESET (nrst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.WR_LOAD = 0; bus.WR_X = '0; bus.WR_DIR = 0; bus.WR_PAL_LD = 0; bus.WR_PAL = '0;
        bus.WR_EN = 0; bus.COLOR_INDEX = '0; bus.RD_START = 0; bus.RD_EN = 0; bus.SWAP = 0;
    endtask

    task automatic cyc();
        @(posedge clk); #1;
        idle();
    endtask

    task automatic clr_exp();
        for (int i = 0; i < 256; i++) exp_line[i] = BD;
    endtask

    // RD_START, then n back-to-back reads checked against exp_line
    task automatic read_range(input string tag, input int cnt);
        bus.RD_START = 1; cyc();
        bus.RD_EN = 1;
        for (int i = 0; i < cnt; i++) begin
            @(posedge clk); #1;
            chk($sformatf("%s[%0d]", tag, i), 32'(bus.DATA_OUT), 32'(exp_line[i]));
        end
        idle();
    endtask

    task automatic swap();
        bus.SWAP = 1; cyc();
    endtask

    task automatic pix(input logic [3:0] idx);
        bus.WR_EN = 1; bus.COLOR_INDEX = idx; cyc();
    endtask

    task automatic wait_busy(output int edges);
        edges = 0;
        do begin
            @(posedge clk); #1;
            edges++;
        end while (bus.BUSY === 1'b1 && edges < 400);
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        idle();
        nrst = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout", 32'(bus.DATA_OUT), 32'h FFF);
        chk("rst_busy", 32'(bus.BUSY), 32'd1);
        chk("rst_bank", 32'(bus.BANK), 32'd0);

        @(negedge clk); nrst = 1;
        wait_busy(n);
        chk("busy_len", 32'(n), 32'd192);
        chk("bank_after_init", 32'(bus.BANK), 32'd0);

        // Both banks read as backdrop after init
        clr_exp();
        read_range("init_b0", DEPTH);
        swap();
        chk("bank_swap1", 32'(bus.BANK), 32'd1);
        read_range("init_b1", DEPTH);
        swap();
        chk("bank_swap2", 32'(bus.BANK), 32'd0);

        // Strip write into bank 1
        bus.WR_PAL_LD = 1; bus.WR_PAL = 8'h5A; cyc();
        bus.WR_LOAD = 1; bus.WR_X = 8'd10; bus.WR_DIR = 0; cyc();
        pix(4'd3); pix(4'd0); pix(4'd7); pix(4'd1);
        swap();
        chk("bank_strip", 32'(bus.BANK), 32'd1);
        clr_exp();
        exp_line[10] = 12'h5A3; exp_line[12] = 12'h5A7; exp_line[13] = 12'h5A1;
        read_range("strip", 200);

        // Clear-behind: same bank again after two empty swaps
        swap(); swap();
        chk("bank_clr", 32'(bus.BANK), 32'd1);
        clr_exp();
        read_range("clr", 196);

        // Flip and wrap into bank 0
        bus.WR_PAL_LD = 1; bus.WR_PAL = 8'h01; cyc();
        bus.WR_LOAD = 1; bus.WR_X = 8'd1; bus.WR_DIR = 1; cyc();
        pix(4'd2); pix(4'd2); pix(4'd2);
        swap();
        chk("bank_flip", 32'(bus.BANK), 32'd0);
        clr_exp();
        exp_line[0] = 12'h012; exp_line[1] = 12'h012;
        read_range("flip", 8);

        // Load+write same cycle with palette change; write in swap cycle
        bus.WR_LOAD = 1; bus.WR_X = 8'd50; bus.WR_DIR = 0;
        bus.WR_PAL_LD = 1; bus.WR_PAL = 8'h77;
        bus.WR_EN = 1; bus.COLOR_INDEX = 4'd5; cyc();
        bus.SWAP = 1; bus.WR_EN = 1; bus.COLOR_INDEX = 4'd9; cyc();
        chk("bank_sim", 32'(bus.BANK), 32'd1);
        clr_exp();
        exp_line[50] = 12'h015; exp_line[51] = 12'h779;
        read_range("sim", 54);

        // Mid-sweep reset restarts the sweep from scratch
        @(negedge clk); nrst = 0;
        @(negedge clk); nrst = 1;
        repeat (100) @(posedge clk);
        #1;
        chk("mid_busy_pre", 32'(bus.BUSY), 32'd1);
        nrst = 0;
        #1;
        chk("mid_busy", 32'(bus.BUSY), 32'd1);
        chk("mid_bank", 32'(bus.BANK), 32'd0);
        @(negedge clk); nrst = 1;
        wait_busy(n);
        chk("mid_busy_len", 32'(n), 32'd192);
        chk("mid_bank_end", 32'(bus.BANK), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sprite_linebuf_pp.md
# sprite_linebuf_pp

Parametrised ping-pong sprite line buffer with two banks. The sprite renderer writes pixels into the back bank while the video scanout reads the front bank. Each front-bank location is cleared to the backdrop code as it is read. The block sits between the sprite pixel pipeline and the palette RAM address mux, and gives the same write/load/clear behaviour as the existing per-line buffers. It adds:
- horizontal flip (decrementing write)
- transparency gating
- a line-swap handshake
- a power-up clear sweep

## Interface
- COLOR_W, 4, colour index width; index 0 is transparent
- PAL_W, 8, palette number width
- DEPTH, 192, pixels per line (valid addresses 0..DEPTH-1)
- ADDR_W, 8, address counter width (2^ADDR_W >= DEPTH)
- CLK  in  1  system clock; all state changes on rising edge
- nRESET  in  1  reset, asynchronous assert, active-low
- WR_LOAD  in  1  load write counter from WR_X this cycle
- WR_X  in  ADDR_W  start X for the next sprite strip
- WR_DIR  in  1  0 = increment after each pixel, 1 = decrement (H-flip); sampled on WR_LOAD
- WR_PAL_LD  in  1  latch WR_PAL into the palette register
- WR_PAL  in  PAL_W  sprite palette number
- WR_EN  in  1  pixel strobe; advances the write counter
- COLOR_INDEX  in  COLOR_W  pixel colour index
- RD_START  in  1  reset the read counter to 0
- RD_EN  in  1  read strobe; advances the read counter
- SWAP  in  1  line boundary; exchange front and back banks
- DATA_OUT  out  PAL_W+COLOR_W  {palette, index} of the pixel read
- BUSY  out  1  init sweep in progress; all requests ignored
- BANK  out  1  index of the current front (read) bank

## Operation
- Storage: two banks, each DEPTH x (PAL_W+COLOR_W).
  - Back bank = ~BANK: write only.
  - Front bank = BANK: read, then clear.
- Backdrop code BD = all ones ({PAL_W+COLOR_W{1'b1}}).
- FSM states:
  - INIT: entered on reset. Writes BD to address k of both banks for k = 0..DEPTH-1, one address per cycle. BUSY = 1. Moves to RUN after DEPTH cycles.
  - RUN: normal operation; BUSY = 0.
  - A reset asserted mid-sweep restarts INIT at k = 0.
- Write path:
  - WR_PAL_LD latches PAL_REG.
  - On WR_LOAD, wcnt <= WR_X and dir <= WR_DIR.
  - On WR_EN, the write address is WR_X if WR_LOAD is also high that cycle, else wcnt. The pixel {PAL_REG, COLOR_INDEX} is written to the back bank at that address.
  - The write is suppressed when COLOR_INDEX == 0 or the address >= DEPTH. The counter still steps.
  - Counter next value = address ± 1 according to the dir in effect, modulo 2^ADDR_W. Example: 0 - 1 = 255 with ADDR_W = 8, which is out of range, so the write is dropped.
  - WR_PAL_LD together with WR_EN: the pixel uses the old PAL_REG.
- Read path:
  - RD_START sets rcnt <= 0. RD_START wins over RD_EN.
  - On RD_EN, the front bank is read at rcnt, the same location is written with BD, and rcnt increments.
  - Once rcnt >= DEPTH, reads return BD, rcnt saturates at DEPTH, and no clear write occurs.
- Swap:
  - On SWAP, BANK toggles, rcnt <= 0, and wcnt is held.
  - A WR_EN in the SWAP cycle writes the old back bank.
  - An RD_EN in the SWAP cycle reads and clears the old front bank.
  - The bank roles change from the next cycle.
- While BUSY, WR_*, RD_*, and SWAP are ignored.

## Timing
- Reset values:
  - DATA_OUT = BD, BUSY = 1, BANK = 0
  - wcnt = 0, rcnt = 0, dir = 0, PAL_REG = 0
- First cycle with BUSY = 0 is cycle DEPTH after nRESET deasserts; requests are accepted in that cycle.
- Read latency: 1 cycle. DATA_OUT updates on the edge after RD_EN and holds its value otherwise.
- Write-to-read visibility: a pixel written in line N appears on DATA_OUT only after SWAP, at the first RD_EN at its address.
- Throughput: one write and one read every cycle, simultaneously, with no stalls.
- Banks need one write port and one read port each. The front bank's clear write uses its write port; write and read data never target the same bank in the same cycle.

## Test plan
- Init sweep: reset with DEPTH = 192 → BUSY high for exactly 192 cycles. After two swaps, every read of both banks returns 0xFFF.
- Strip write: WR_PAL_LD with 0x5A; WR_LOAD with X = 10, dir 0; 4 × WR_EN with indices 3, 0, 7, 1; SWAP; RD_START; 16 reads → addresses 10 = 0x5A3, 12 = 0x5A7, 13 = 0x5A1; address 11 and all others = 0xFFF.
- Flip and wrap: WR_LOAD with X = 1, dir 1; 3 pixels with index 2, PAL 0x01 → addresses 1 and 0 = 0x012. The third write (address 255) is dropped and wcnt = 254.
- Clear-behind: read a line, SWAP twice with no writes, re-read → all 0xFFF. Reading past address 191 returns 0xFFF.
- Simultaneous events: SWAP and WR_EN in the same cycle → the pixel lands in the old back bank, which is the front bank after the swap and readable immediately. WR_LOAD and WR_EN in the same cycle → pixel written at WR_X.
- Mid-sweep reset: assert nRESET at sweep cycle 100 → BUSY stays high for a full 192 cycles after deassert, and BANK = 0.
